// File: rtl/wts_timer_counter_if.sv
// rtl/wts_timer_counter_if.sv - register/trigger bundle between the CPU register block and the timer core
interface wts_timer_counter_if;
  logic [7:0] reg_timer1_period;
  logic       reg_timer1_run;
  logic       reg_timer1_load;
  logic [7:0] reg_timer2_period;
  logic       reg_timer2_run;
  logic       reg_timer2_load;
  logic       timer1_trigger;
  logic       timer2_trigger;
  logic [7:0] timer1_count;
  logic [7:0] timer2_count;

  modport master (
    output reg_timer1_period, reg_timer1_run, reg_timer1_load,
    output reg_timer2_period, reg_timer2_run, reg_timer2_load,
    input  timer1_trigger, timer2_trigger, timer1_count, timer2_count
  );

  modport slave (
    input  reg_timer1_period, reg_timer1_run, reg_timer1_load,
    input  reg_timer2_period, reg_timer2_run, reg_timer2_load,
    output timer1_trigger, timer2_trigger, timer1_count, timer2_count
  );
endinterface

// File: rtl/wts_timer_counter.sv
// rtl/wts_timer_counter.sv - shared prescaler plus two reloading down-counter timers
module wts_timer_counter #(
  parameter int PRESCALE_DIV = 64
) (
  input  logic                 clk,
  input  logic                 nreset,
  wts_timer_counter_if.slave   bus
);

  localparam int PW = (PRESCALE_DIV > 2) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [3:0]    r_sub;
  logic [7:0]    r_cnt1;
  logic [7:0]    r_cnt2;
  logic          r_trig1;
  logic          r_trig2;

  logic          w_base_tick;
  logic          w_tick1;
  logic          w_tick2;

  assign w_base_tick = (r_pre == PRE_LAST);
  assign w_tick1     = w_base_tick;
  assign w_tick2     = w_base_tick && (r_sub == 4'd15);

  // Free-running: the run inputs never gate the base tick phase.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_pre <= '0;
    end else if (w_base_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sub <= 4'd0;
    end else if (!bus.reg_timer2_run || bus.reg_timer2_load) begin
      r_sub <= 4'd0;
    end else if (w_base_tick) begin
      r_sub <= r_sub + 4'd1;
    end
  end

  // A loaded 0 walks through 255 down to 1, giving a 256-tick interval.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt1  <= 8'd0;
      r_trig1 <= 1'b0;
    end else begin
      r_trig1 <= 1'b0;
      if (bus.reg_timer1_load || !bus.reg_timer1_run) begin
        r_cnt1 <= bus.reg_timer1_period;
      end else if (w_tick1 && (r_cnt1 == 8'd1)) begin
        r_cnt1  <= bus.reg_timer1_period;
        r_trig1 <= 1'b1;
      end else if (w_tick1) begin
        r_cnt1 <= r_cnt1 - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt2  <= 8'd0;
      r_trig2 <= 1'b0;
    end else begin
      r_trig2 <= 1'b0;
      if (bus.reg_timer2_load || !bus.reg_timer2_run) begin
        r_cnt2 <= bus.reg_timer2_period;
      end else if (w_tick2 && (r_cnt2 == 8'd1)) begin
        r_cnt2  <= bus.reg_timer2_period;
        r_trig2 <= 1'b1;
      end else if (w_tick2) begin
        r_cnt2 <= r_cnt2 - 8'd1;
      end
    end
  end

  assign bus.timer1_trigger = r_trig1;
  assign bus.timer2_trigger = r_trig2;
  assign bus.timer1_count   = r_cnt1;
  assign bus.timer2_count   = r_cnt2;

endmodule
